udp_tx_scheduler: RTL and testbench

Packet-granular arbiter that shares the single 8-bit UDP TX AXI-stream of `udp_connection` between two byte-stream requesters. Requester 0 is the CBF spectrum estimator output; requester 1 is an auxiliary status/telemetry source. The block grants whole frames round-robin and enforces a maximum frame length and a mid-frame stall timeout, so a misbehaving source can neither hog nor wedge the UDP transmitter. It exports per-source frame counters and an error counter.

---
 rtl/udp_tx_scheduler_if.sv | 26 ++
 rtl/udp_tx_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_scheduler_if.sv
// Byte-lane AXI-stream bundle shared by the scheduler's requester and UDP-side ports.
interface udp_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    input  tready,
    output tlast,
    output tuser
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready,
    input  tlast,
    input  tuser
  );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Frame-granular round-robin arbiter feeding the UDP TX payload stream from two
// byte-stream requesters. Oversized frames are truncated (tlast+tuser forced),
// frames whose source stalls too long are closed with a padding beat, and the
// remainder of any offending frame is swallowed before the next grant.
module udp_tx_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_FRAME_LEN  = 88,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  udp_tx_scheduler_if.slave    s0_axis,
  udp_tx_scheduler_if.slave    s1_axis,
  udp_tx_scheduler_if.master   m_axis,
  output logic [CNT_WIDTH-1:0] frame_count0,
  output logic [CNT_WIDTH-1:0] frame_count1,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [1:0]           grant
);

  localparam int BEAT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_PAD,
    ST_DROP
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          grant_nxt;
  logic                last_grant, last_grant_nxt;   // 1 = source 1 completed last
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic                fc0_inc, fc1_inc, err_inc;

  logic [DATA_WIDTH-1:0] src_tdata;
  logic                  src_tvalid, src_tlast, src_tuser, src_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid, m_tlast, m_tuser;
  logic                  at_limit;

  // Saturating increment used by the error counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Select the currently granted requester onto a common set of source signals.
  always_comb begin
    if (grant[1]) begin
      src_tdata  = s1_axis.tdata;
      src_tvalid = s1_axis.tvalid;
      src_tlast  = s1_axis.tlast;
      src_tuser  = s1_axis.tuser;
    end else begin
      src_tdata  = s0_axis.tdata;
      src_tvalid = s0_axis.tvalid;
      src_tlast  = s0_axis.tlast;
      src_tuser  = s0_axis.tuser;
    end
  end

  assign at_limit = (beat_cnt == BEAT_W'(MAX_FRAME_LEN - 1));

  // Next-state, output and counter-strobe logic for the frame scheduler FSM.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    idle_cnt_nxt   = idle_cnt;
    fc0_inc        = 1'b0;
    fc1_inc        = 1'b0;
    err_inc        = 1'b0;
    m_tdata        = '0;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    m_tuser        = 1'b0;
    src_tready     = 1'b0;

    case (state)
      ST_IDLE: begin
        beat_cnt_nxt = '0;
        idle_cnt_nxt = '0;
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          // Tie: hand the bus to whichever source did not finish last.
          grant_nxt = last_grant ? 2'b01 : 2'b10;
          state_nxt = ST_PASS;
        end else if (s0_axis.tvalid) begin
          grant_nxt = 2'b01;
          state_nxt = ST_PASS;
        end else if (s1_axis.tvalid) begin
          grant_nxt = 2'b10;
          state_nxt = ST_PASS;
        end
      end

      ST_PASS: begin
        m_tvalid   = src_tvalid;
        src_tready = m_axis.tready;
        if (src_tvalid) begin
          m_tdata = src_tdata;
          // The final permitted beat always closes the frame; it is flagged
          // bad only when the source had not finished the frame itself.
          m_tlast = src_tlast | at_limit;
          m_tuser = src_tuser | (at_limit & ~src_tlast);
        end
        if (src_tvalid && m_axis.tready) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (src_tlast) begin
            fc0_inc        = grant[0];
            fc1_inc        = grant[1];
            last_grant_nxt = grant[1];
            grant_nxt      = 2'b00;
            state_nxt      = ST_IDLE;
          end else if (at_limit) begin
            err_inc   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
        // Only source silence counts toward the timeout; a downstream stall
        // with data pending keeps the counter cleared.
        if (src_tvalid) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt_nxt = '0;
          state_nxt    = ST_PAD;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end

      ST_PAD: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_axis.tready) begin
          err_inc   = 1'b1;
          state_nxt = ST_DROP;
        end
      end

      ST_DROP: begin
        src_tready = 1'b1;
        if (src_tvalid && src_tlast) begin
          last_grant_nxt = grant[1];
          grant_nxt      = 2'b00;
          state_nxt      = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // FSM state, grant bookkeeping and per-frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      grant        <= 2'b00;
      last_grant   <= 1'b1;
      beat_cnt     <= '0;
      idle_cnt     <= '0;
      frame_count0 <= '0;
      frame_count1 <= '0;
      error_count  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
      if (fc0_inc) frame_count0 <= frame_count0 + 1'b1;
      if (fc1_inc) frame_count1 <= frame_count1 + 1'b1;
      if (err_inc) error_count  <= sat_inc(error_count);
    end
  end

  assign s0_axis.tready = src_tready & grant[0];
  assign s1_axis.tready = src_tready & grant[1];
  assign m_axis.tdata   = m_tdata;
  assign m_axis.tvalid  = m_tvalid;
  assign m_axis.tlast   = m_tlast;
  assign m_axis.tuser   = m_tuser;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: a frame-level model predicts the output
// beat sequence and counters; a monitor compares every output handshake.
module tb_udp_tx_scheduler;
  localparam int DW   = 8;
  localparam int MAXL = 88;
  localparam int TMO  = 1024;
  localparam int CW   = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
    logic [1:0] g;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_tx_scheduler_if #(.DATA_WIDTH(DW)) s0_if ();
  udp_tx_scheduler_if #(.DATA_WIDTH(DW)) s1_if ();
  udp_tx_scheduler_if #(.DATA_WIDTH(DW)) m_if ();

  logic [DW-1:0] s_tdata  [2];
  logic          s_tvalid [2];
  logic          s_tlast  [2];
  logic          s_tuser  [2];
  logic          m_tready;
  logic [CW-1:0] fc0, fc1, errc;
  logic [1:0]    grant;

  assign s0_if.tdata  = s_tdata[0];
  assign s0_if.tvalid = s_tvalid[0];
  assign s0_if.tlast  = s_tlast[0];
  assign s0_if.tuser  = s_tuser[0];
  assign s1_if.tdata  = s_tdata[1];
  assign s1_if.tvalid = s_tvalid[1];
  assign s1_if.tlast  = s_tlast[1];
  assign s1_if.tuser  = s_tuser[1];
  assign m_if.tready  = m_tready;

  udp_tx_scheduler #(
    .DATA_WIDTH    (DW),
    .MAX_FRAME_LEN (MAXL),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s0_axis     (s0_if),
    .s1_axis     (s1_if),
    .m_axis      (m_if),
    .frame_count0(fc0),
    .frame_count1(fc1),
    .error_count (errc),
    .grant       (grant)
  );

  int    tests_run = 0;
  int    tests_failed = 0;
  int    beats_seen = 0;
  bit    abort = 1'b0;
  beat_t exp_q[$];
  int    mf0, mf1, merr, m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic int pick(input bit p0, input bit p1);
    if (p0 && p1) return (m_last == 1) ? 0 : 1;
    return p0 ? 0 : 1;
  endfunction

  task automatic model_frame(input int src, input int len, input logic [7:0] base,
                             input logic user, input int gap_after, input int gap_len);
    beat_t b;
    logic [1:0] g = (src == 1) ? 2'b10 : 2'b01;
    if (gap_after > 0 && gap_len >= TMO) begin
      for (int i = 0; i < gap_after; i++) begin
        b = '{d: 8'(int'(base) + i), l: 1'b0, u: user, g: g};
        exp_q.push_back(b);
      end
      b = '{d: 8'h00, l: 1'b1, u: 1'b1, g: g};
      exp_q.push_back(b);
      if (merr < 65535) merr++;
    end else if (len > MAXL) begin
      for (int i = 0; i < MAXL; i++) begin
        b = '{d: 8'(int'(base) + i), l: (i == MAXL - 1), u: (i == MAXL - 1) ? 1'b1 : user, g: g};
        exp_q.push_back(b);
      end
      if (merr < 65535) merr++;
    end else begin
      for (int i = 0; i < len; i++) begin
        b = '{d: 8'(int'(base) + i), l: (i == len - 1), u: user, g: g};
        exp_q.push_back(b);
      end
      if (src == 0) mf0 = (mf0 + 1) % 65536;
      else          mf1 = (mf1 + 1) % 65536;
    end
    m_last = src;
  endtask

  // ---------------- output monitor ----------------
  initial begin
    beat_t cur, prev_beat, e;
    logic  prev_stall, prev_last_hs;
    prev_stall = 1'b0;
    prev_last_hs = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_last_hs = 1'b0;
        continue;
      end
      cur = {m_if.tdata, m_if.tlast, m_if.tuser, grant};
      if (prev_stall) begin
        check("hold_valid", 32'(m_if.tvalid), 32'd1);
        check("hold_beat", 32'(cur), 32'(prev_beat));
      end
      if (prev_last_hs) check("frame_gap", 32'(m_if.tvalid), 32'd0);
      if (m_if.tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_beat actual=%h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(cur), 32'(e));
        end
        beats_seen++;
      end
      prev_stall   = m_if.tvalid && !m_tready;
      prev_beat    = cur;
      prev_last_hs = m_if.tvalid && m_tready && m_if.tlast;
    end
  end

  // ---------------- source driver ----------------
  task automatic send(input int src, input int len, input logic [7:0] base, input logic user,
                      input int gap_after, input int gap_len, output int first_wait);
    bit hs, bail;
    int waited;
    first_wait = 0;
    bail = 1'b0;
    for (int i = 0; i < len && !bail && !abort; i++) begin
      if (gap_after > 0 && i == gap_after) begin
        s_tvalid[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      s_tvalid[src] = 1'b1;
      s_tdata[src]  = 8'(int'(base) + i);
      s_tlast[src]  = (i == len - 1);
      s_tuser[src]  = user;
      hs = 1'b0;
      waited = 0;
      while (!hs && !abort && !bail) begin
        @(negedge clk);
        hs = (src == 0) ? s0_if.tready : s1_if.tready;
        @(posedge clk);
        #1;
        if (!hs) begin
          waited++;
          if (waited > 5000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drv_timeout src=%0d beat=%0d actual=no_ready required=ready", src, i);
            bail = 1'b1;
          end
        end
      end
      if (i == 0) first_wait = waited;
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
    s_tuser[src]  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mf0 = 0;
    mf1 = 0;
    merr = 0;
    m_last = 1;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_fc0"}, 32'(fc0), 32'(mf0));
    check({name, "_fc1"}, 32'(fc1), 32'(mf1));
    check({name, "_err"}, 32'(errc), 32'(merr));
    check({name, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int fw, fw1, first_src, k, base_seen;
    logic [3:0] order;
    beat_t lastb;
    for (int s = 0; s < 2; s++) begin
      s_tdata[s] = '0;
      s_tvalid[s] = 1'b0;
      s_tlast[s] = 1'b0;
      s_tuser[s] = 1'b0;
    end
    m_tready = 1'b1;
    mf0 = 0; mf1 = 0; merr = 0; m_last = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tlast",  32'(m_if.tlast),  32'd0);
    check("rst_tuser",  32'(m_if.tuser),  32'd0);
    check("rst_tdata",  32'(m_if.tdata),  32'd0);
    check("rst_rdy0",   32'(s0_if.tready), 32'd0);
    check("rst_rdy1",   32'(s1_if.tready), 32'd0);
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_cnt",    32'({fc0, fc1, errc}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 10-byte frame on s0
    model_frame(0, 10, 8'h01, 1'b0, 0, 0);
    send(0, 10, 8'h01, 1'b0, 0, 0, fw);
    check("t1_first_wait", 32'(fw), 32'd1);
    drain("t1_drained");
    check_counts("t1");
    check("t1_fc0_lit", 32'(fc0), 32'd1);

    // Both sources offering two 4-byte frames each
    do_reset();
    order = '0;
    begin
      int n0 = 2, n1 = 2, c0 = 0, c1 = 0;
      for (int f = 0; f < 4; f++) begin
        first_src = pick(n0 > 0, n1 > 0);
        order[3 - f] = first_src[0];
        if (first_src == 0) begin
          model_frame(0, 4, 8'(8'h10 + 8'h10 * c0), 1'b0, 0, 0);
          c0++; n0--;
        end else begin
          model_frame(1, 4, 8'(8'h30 + 8'h10 * c1), 1'b1, 0, 0);
          c1++; n1--;
        end
      end
    end
    check("t2_model_order", 32'(order), 32'b0101);
    fork
      begin
        send(0, 4, 8'h10, 1'b0, 0, 0, fw);
        send(0, 4, 8'h20, 1'b0, 0, 0, fw);
      end
      begin
        send(1, 4, 8'h30, 1'b1, 0, 0, fw1);
        send(1, 4, 8'h40, 1'b1, 0, 0, fw1);
      end
    join
    drain("t2_drained");
    check_counts("t2");
    check("t2_lit", 32'({fc0, fc1}), {16'd2, 16'd2});

    // 100-byte frame on s1: truncated at 88 beats
    model_frame(1, 100, 8'h01, 1'b0, 0, 0);
    check("t3_model_len", 32'(exp_q.size()), 32'd88);
    lastb = exp_q[87];
    check("t3_model_tail", 32'({lastb.d, lastb.l, lastb.u}), 32'({8'd88, 1'b1, 1'b1}));
    send(1, 100, 8'h01, 1'b0, 0, 0, fw);
    drain("t3_drained");
    check_counts("t3");
    check("t3_lit", 32'({fc1, errc}), {16'd2, 16'd1});

    // s0 stalls for exactly the timeout after 3 bytes: pad beat, then drop
    model_frame(0, 6, 8'h51, 1'b0, 3, TMO);
    send(0, 6, 8'h51, 1'b0, 3, TMO, fw);
    drain("t4_drained");
    check_counts("t4");
    check("t4_err_lit", 32'(errc), 32'd2);

    // One idle cycle short of the timeout: normal completion
    model_frame(0, 6, 8'h61, 1'b0, 3, TMO - 1);
    send(0, 6, 8'h61, 1'b0, 3, TMO - 1, fw);
    drain("t4b_drained");
    check_counts("t4b");
    check("t4b_fc0_lit", 32'(fc0), 32'd3);

    // Downstream stall of 2000 cycles mid-frame
    model_frame(1, 8, 8'h71, 1'b0, 0, 0);
    fork
      send(1, 8, 8'h71, 1'b0, 0, 0, fw);
      begin
        repeat (4) @(posedge clk);
        #1;
        m_tready = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain("t5_drained");
    check_counts("t5");
    check("t5_lit", 32'({fc1, errc}), {16'd3, 16'd2});

    // Length limit: tlast exactly on beat 88 is normal, 89 bytes truncates
    model_frame(0, 88, 8'h00, 1'b0, 0, 0);
    send(0, 88, 8'h00, 1'b0, 0, 0, fw);
    drain("t6a_drained");
    check("t6a_lit", 32'({fc0, errc}), {16'd4, 16'd2});
    model_frame(0, 89, 8'h00, 1'b0, 0, 0);
    send(0, 89, 8'h00, 1'b0, 0, 0, fw);
    drain("t6b_drained");
    check_counts("t6b");
    check("t6b_lit", 32'({fc0, errc}), {16'd4, 16'd3});

    // Asynchronous reset during a frame
    model_frame(0, 10, 8'h81, 1'b0, 0, 0);
    base_seen = beats_seen;
    fork
      send(0, 10, 8'h81, 1'b0, 0, 0, fw);
      begin
        k = 0;
        while (beats_seen < base_seen + 5 && k < 100) begin
          @(posedge clk);
          k++;
        end
        check("t7_reached_beat5", 32'(beats_seen - base_seen), 32'd5);
        #3;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check("t7_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t7_tdata_flags", 32'({m_if.tdata, m_if.tlast, m_if.tuser}), 32'd0);
        check("t7_readies", 32'({s0_if.tready, s1_if.tready}), 32'd0);
        check("t7_grant", 32'(grant), 32'd0);
        check("t7_counters", 32'(fc0) + 32'(fc1) + 32'(errc), 32'd0);
        exp_q.delete();
        mf0 = 0; mf1 = 0; merr = 0; m_last = 1;
        repeat (3) @(posedge clk);
      end
    join
    #1;
    abort = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    first_src = pick(1'b1, 1'b1);
    check("t7_model_tie", 32'(first_src), 32'd0);
    model_frame(0, 3, 8'h91, 1'b0, 0, 0);
    model_frame(1, 3, 8'hA1, 1'b1, 0, 0);
    fork
      send(0, 3, 8'h91, 1'b0, 0, 0, fw);
      send(1, 3, 8'hA1, 1'b1, 0, 0, fw1);
    join
    check("t7_tie_latency", 32'(fw), 32'd1);
    drain("t7_drained");
    check_counts("t7");

    // After reset, a lone s1 frame is granted immediately
    do_reset();
    model_frame(1, 5, 8'hB1, 1'b0, 0, 0);
    send(1, 5, 8'hB1, 1'b0, 0, 0, fw);
    check("t8_latency", 32'(fw), 32'd1);
    drain("t8_drained");
    check_counts("t8");
    check("t8_lit", 32'({fc0, fc1}), {16'd0, 16'd1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
